// File: rtl/slot_spi_controller.sv
// slot_spi_controller
//
// Runs converter register accesses on the slot SPI pins. The block takes one command at a
// time from the FX2 command decoder and sends it as a 16-bit mode-0 frame, MSB first:
// {rw, addr[6:0], data}. The frame goes to either the DAC bus or the ADC bus. For a read,
// the last 8 bits sampled on rising mclk are returned on the response port. Only the
// targeted bus toggles. The other bus stays at cs=1, mclk=0, mdi=0.
//
// Frame phases, each CLK_DIV clk cycles long:
//   setup, then 16 x (mclk low, mclk high), then hold, then gap.
//   This gives 35*CLK_DIV cycles from accept back to idle.
//
// Ports:
//   clk, reset             system clock; synchronous active-high reset
//   cmd_in_id              [15] read, [14] target (1 = ADC), [6:0] register address
//   cmd_in_data            write data (ignored for reads)
//   cmd_valid, cmd_ready   command strobe / accept window
//   resp_data, resp_valid  readback byte and its flag; resp_read clears the flag
//   cmd_drop_count         saturating count of strobes seen while not ready
//   spi_{adc,dac}_cs       active-low chip selects
//   spi_{adc,dac}_mclk     SPI clocks
//   spi_{adc,dac}_mdi      controller-to-converter data
//   spi_{adc,dac}_mdo      converter-to-controller data
//
// Build option:
//   SPI_LOOPBACK_EN  When defined, received bits come from the controller's own mdi of the
//                    targeted bus, and the mdo pins are not used. Pin timing does not change.

module slot_spi_controller #(
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cmd_in_id,
  input  logic [7:0]  cmd_in_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  input  logic        resp_read,
  output logic [7:0]  cmd_drop_count,
  output logic        spi_adc_cs,
  output logic        spi_adc_mclk,
  output logic        spi_adc_mdi,
  input  logic        spi_adc_mdo,
  output logic        spi_dac_cs,
  output logic        spi_dac_mclk,
  output logic        spi_dac_mdi,
  input  logic        spi_dac_mdo
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [3:0] BitLast = 4'(FRAME_BITS - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  // tx_q[15] is the bit currently on mdi. It shifts left as each bit's high phase ends,
  // so the register is all zero once the frame is done.
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic        target_q, target_d;
  logic        cs_q, cs_d;
  logic        mclk_q, mclk_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  drop_q, drop_d;

  logic        phase_end;
  logic        sample_bit;

`ifdef SPI_LOOPBACK_EN
  logic unused_mdo;
  assign unused_mdo = spi_adc_mdo ^ spi_dac_mdo;
  assign sample_bit = tx_q[15];
`else
  assign sample_bit = target_q ? spi_adc_mdo : spi_dac_mdo;
`endif

  assign phase_end = (div_q == DivLast);
  assign cmd_ready = (state_q == StIdle) && !resp_valid_q;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rw_d         = rw_q;
    target_d     = target_q;
    cs_d         = cs_q;
    mclk_d       = mclk_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    drop_d       = drop_q;

    if (cmd_valid && !cmd_ready && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    if (resp_read && resp_valid_q) begin
      resp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = StSetup;
          div_d    = 8'd0;
          bit_d    = 4'd0;
          rw_d     = cmd_in_id[15];
          target_d = cmd_in_id[14];
          tx_d     = {cmd_in_id[15], cmd_in_id[6:0], cmd_in_id[15] ? 8'h00 : cmd_in_data};
          cs_d     = 1'b0;
          mclk_d   = 1'b0;
        end
      end

      StSetup: begin
        if (phase_end) begin
          div_d   = 8'd0;
          state_d = StShift;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      StShift: begin
        if (phase_end) begin
          div_d = 8'd0;
          if (!mclk_q) begin
            // Rising mclk: capture the incoming bit on the same edge.
            mclk_d = 1'b1;
            rx_d   = {rx_q[6:0], sample_bit};
          end else begin
            // Falling mclk: present the next bit.
            mclk_d = 1'b0;
            tx_d   = {tx_q[14:0], 1'b0};
            if (bit_q == BitLast) begin
              state_d = StHold;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      StHold: begin
        if (phase_end) begin
          div_d   = 8'd0;
          state_d = StGap;
          cs_d    = 1'b1;
          if (rw_q) begin
            resp_data_d  = rx_q;
            resp_valid_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      StGap: begin
        if (phase_end) begin
          div_d   = 8'd0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      div_q        <= 8'd0;
      bit_q        <= 4'd0;
      tx_q         <= 16'h0000;
      rx_q         <= 8'h00;
      rw_q         <= 1'b0;
      target_q     <= 1'b0;
      cs_q         <= 1'b1;
      mclk_q       <= 1'b0;
      resp_data_q  <= 8'h00;
      resp_valid_q <= 1'b0;
      drop_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rw_q         <= rw_d;
      target_q     <= target_d;
      cs_q         <= cs_d;
      mclk_q       <= mclk_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign resp_data      = resp_data_q;
  assign resp_valid     = resp_valid_q;
  assign cmd_drop_count = drop_q;

  // The idle bus is forced to cs=1, mclk=0, mdi=0.
  assign spi_adc_cs   = target_q ? cs_q : 1'b1;
  assign spi_adc_mclk = target_q & mclk_q;
  assign spi_adc_mdi  = target_q & tx_q[15];
  assign spi_dac_cs   = target_q ? 1'b1 : cs_q;
  assign spi_dac_mclk = !target_q & mclk_q;
  assign spi_dac_mdi  = !target_q & tx_q[15];

endmodule

// File: tb/tb_slot_spi_controller.sv
// Self-checking bench for slot_spi_controller. It uses a table of directed commands, random
// commands checked against a frame-level model, and hand-written sequences for busy drops,
// response blocking and a reset in the middle of a frame.

module tb_slot_spi_controller;

  localparam int DIV = 8;
`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cmd_in_id = 16'h0000;
  logic [7:0]  cmd_in_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_read = 1'b0;
  logic [7:0]  cmd_drop_count;
  logic        spi_adc_cs, spi_adc_mclk, spi_adc_mdi;
  logic        spi_dac_cs, spi_dac_mclk, spi_dac_mdi;
  logic        spi_adc_mdo = 1'b0;
  logic        spi_dac_mdo = 1'b0;

  slot_spi_controller #(
    .CLK_DIV    (DIV),
    .FRAME_BITS (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_in_id      (cmd_in_id),
    .cmd_in_data    (cmd_in_data),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .resp_data      (resp_data),
    .resp_valid     (resp_valid),
    .resp_read      (resp_read),
    .cmd_drop_count (cmd_drop_count),
    .spi_adc_cs     (spi_adc_cs),
    .spi_adc_mclk   (spi_adc_mclk),
    .spi_adc_mdi    (spi_adc_mdi),
    .spi_adc_mdo    (spi_adc_mdo),
    .spi_dac_cs     (spi_dac_cs),
    .spi_dac_mclk   (spi_dac_mclk),
    .spi_dac_mdi    (spi_dac_mdi),
    .spi_dac_mdo    (spi_dac_mdo)
  );

  always #5 clk = ~clk;

  // Converter model: it shifts slave_word out MSB first and changes mdo on falling mclk.
  logic [15:0] slave_word = 16'h0000;
  int adc_idx = 0;
  int dac_idx = 0;

  always @(negedge spi_adc_cs) begin
    adc_idx = 0;
    spi_adc_mdo = slave_word[15];
  end
  always @(negedge spi_adc_mclk) begin
    if (!spi_adc_cs) begin
      adc_idx++;
      spi_adc_mdo = (adc_idx < 16) ? slave_word[15 - adc_idx] : 1'b0;
    end
  end
  always @(negedge spi_dac_cs) begin
    dac_idx = 0;
    spi_dac_mdo = slave_word[15];
  end
  always @(negedge spi_dac_mclk) begin
    if (!spi_dac_cs) begin
      dac_idx++;
      spi_dac_mdo = (dac_idx < 16) ? slave_word[15 - dac_idx] : 1'b0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int drop_exp = 0;
  logic [7:0] last_resp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Runs one command from accept until the frame is fully finished. busy_n strobes go out
  // starting busy_start cycles after the accept.
  task automatic do_cmd(input string name, input logic [15:0] id, input logic [7:0] data,
                        input logic [7:0] slave, input logic [15:0] exp_frame,
                        input logic [7:0] exp_resp, input int busy_start, input int busy_n,
                        input bit do_ack);
    int cs_low, edges, first_rise, rv_at, rdy_at, quiet_err;
    logic [15:0] cap;
    logic [7:0]  rd_at_rv;
    logic        prev, t_cs, t_mclk, t_mdi, o_cs, o_mclk, o_mdi;
    bit          is_read, tgt;
    is_read = id[15];
    tgt = id[14];
    cs_low = 0; edges = 0; first_rise = -1; rv_at = -1; rdy_at = -1; quiet_err = 0;
    cap = 16'h0000; rd_at_rv = 8'h00; prev = 1'b0;
    check({name, "/ready_before"}, cmd_ready, 1);
    slave_word = {~slave, slave};
    cmd_in_id = id;
    cmd_in_data = data;
    cmd_valid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 36 * DIV; n++) begin
      if (n >= busy_start && n < busy_start + busy_n) begin
        cmd_valid = 1'b1;
        cmd_in_id = tgt ? 16'h8000 : 16'hC000;
      end else begin
        cmd_valid = 1'b0;
      end
      t_cs   = tgt ? spi_adc_cs : spi_dac_cs;
      t_mclk = tgt ? spi_adc_mclk : spi_dac_mclk;
      t_mdi  = tgt ? spi_adc_mdi : spi_dac_mdi;
      o_cs   = tgt ? spi_dac_cs : spi_adc_cs;
      o_mclk = tgt ? spi_dac_mclk : spi_adc_mclk;
      o_mdi  = tgt ? spi_dac_mdi : spi_adc_mdi;
      if (!t_cs) cs_low++;
      if (t_mclk && !prev) begin
        edges++;
        cap = {cap[14:0], t_mdi};
        if (first_rise < 0) first_rise = n;
      end
      prev = t_mclk;
      if (o_cs !== 1'b1 || o_mclk !== 1'b0 || o_mdi !== 1'b0) quiet_err++;
      if (resp_valid && rv_at < 0) begin
        rv_at = n;
        rd_at_rv = resp_data;
      end
      if (cmd_ready && rdy_at < 0) rdy_at = n;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check({name, "/cs_low_cycles"}, cs_low, 34 * DIV);
    check({name, "/first_mclk_rise"}, first_rise, 2 * DIV);
    check({name, "/mclk_rises"}, edges, 16);
    check({name, "/frame"}, cap, exp_frame);
    check({name, "/other_bus_quiet"}, quiet_err, 0);
    drop_exp = (drop_exp + busy_n > 255) ? 255 : drop_exp + busy_n;
    check({name, "/drop_count"}, cmd_drop_count, drop_exp);
    if (!is_read) begin
      check({name, "/no_resp_valid"}, rv_at, -1);
      check({name, "/ready_latency"}, rdy_at, 35 * DIV);
      check({name, "/resp_data_kept"}, resp_data, last_resp);
    end else begin
      check({name, "/resp_valid_at"}, rv_at, 34 * DIV);
      check({name, "/resp_data"}, rd_at_rv, exp_resp);
      check({name, "/ready_blocked"}, rdy_at, -1);
      check({name, "/resp_held"}, resp_valid, 1);
      last_resp = exp_resp;
      if (do_ack) begin
        resp_read = 1'b1;
        @(negedge clk);
        resp_read = 1'b0;
        check({name, "/resp_cleared"}, resp_valid, 0);
        check({name, "/ready_after_ack"}, cmd_ready, 1);
      end
    end
  endtask

  typedef struct {
    logic [15:0] id;
    logic [7:0]  data;
    logic [7:0]  slave;
    logic [15:0] frame;
    logic [7:0]  resp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [15:0] rid, rframe;
    logic [7:0]  rdata, rslave, rresp;
    int          edges;
    logic        prev;
    int          dac_cs_low;

    tbl[0] = '{id: 16'h0005, data: 8'hA3, slave: 8'h00, frame: 16'h05A3, resp: 8'h00};
    tbl[1] = '{id: 16'hC010, data: 8'hFF, slave: 8'h5C, frame: 16'h9000,
               resp: LOOPBACK ? 8'h00 : 8'h5C};
    tbl[2] = '{id: 16'h4C7F, data: 8'h3C, slave: 8'h77, frame: 16'h7F3C, resp: 8'h00};
    tbl[3] = '{id: 16'h8000, data: 8'h55, slave: 8'hE1, frame: 16'h8000,
               resp: LOOPBACK ? 8'h00 : 8'hE1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/cmd_ready", cmd_ready, 1);
    check("rst/resp_valid", resp_valid, 0);
    check("rst/resp_data", resp_data, 8'h00);
    check("rst/drop_count", cmd_drop_count, 0);
    check("rst/pins", {spi_adc_cs, spi_adc_mclk, spi_adc_mdi, spi_dac_cs, spi_dac_mclk,
                       spi_dac_mdi}, 6'b100100);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_cmd($sformatf("vec%0d", i), tbl[i].id, tbl[i].data, tbl[i].slave, tbl[i].frame,
             tbl[i].resp, 0, 0, 1'b1);
    end

    // Busy drops: one strobe, then enough to hit saturation
    do_cmd("busy1", 16'h0012, 8'h5A, 8'h00, 16'h125A, 8'h00, 50, 1, 1'b1);
    do_cmd("busy2", 16'h0013, 8'hC3, 8'h00, 16'h13C3, 8'h00, 10, 251, 1'b1);
    do_cmd("busy3", 16'h4014, 8'h0F, 8'h00, 16'h140F, 8'h00, 10, 251, 1'b1);

    // Response blocking: an unacknowledged read holds off new commands
    do_cmd("block_rd", 16'hC023, 8'h00, 8'hA5, 16'hA300, LOOPBACK ? 8'h00 : 8'hA5, 0, 0, 1'b0);
    cmd_in_id = 16'h0001;
    cmd_in_data = 8'h11;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    dac_cs_low = 0;
    repeat (4) begin
      if (!spi_dac_cs) dac_cs_low++;
      @(negedge clk);
    end
    check("block/no_frame", dac_cs_low, 0);
    drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
    check("block/drop_count", cmd_drop_count, drop_exp);
    check("block/ready_low", cmd_ready, 0);
    resp_read = 1'b1;
    @(negedge clk);
    resp_read = 1'b0;
    check("block/ready_after_ack", cmd_ready, 1);
    check("block/resp_cleared", resp_valid, 0);
    do_cmd("block_wr", 16'h0001, 8'h11, 8'h00, 16'h0111, 8'h00, 0, 0, 1'b1);

    // Random commands against the frame-level model
    for (int i = 0; i < 12; i++) begin
      rid = 16'($urandom);
      rdata = 8'($urandom);
      rslave = 8'($urandom);
      rframe = {rid[15], rid[6:0], rid[15] ? 8'h00 : rdata};
      rresp = LOOPBACK ? rframe[7:0] : rslave;
      do_cmd($sformatf("rand%0d", i), rid, rdata, rslave, rframe, rresp, 0, 0, 1'b1);
    end

    // Reset during bit 6 of a DAC write
    cmd_in_id = 16'h0033;
    cmd_in_data = 8'h99;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    edges = 0;
    prev = 1'b0;
    for (int n = 0; n < 40 * DIV; n++) begin
      if (spi_dac_mclk && !prev) edges++;
      prev = spi_dac_mclk;
      if (edges >= 10) break;
      @(negedge clk);
    end
    check("midrst/reached_bit6", edges, 10);
    reset = 1'b1;
    @(negedge clk);
    check("midrst/dac_pins", {spi_dac_cs, spi_dac_mclk, spi_dac_mdi}, 3'b100);
    check("midrst/adc_pins", {spi_adc_cs, spi_adc_mclk, spi_adc_mdi}, 3'b100);
    check("midrst/cmd_ready", cmd_ready, 1);
    check("midrst/resp_valid", resp_valid, 0);
    check("midrst/resp_data", resp_data, 8'h00);
    check("midrst/drop_count", cmd_drop_count, 0);
    reset = 1'b0;
    drop_exp = 0;
    last_resp = 8'h00;
    @(negedge clk);
    do_cmd("after_rst", 16'hC07E, 8'h00, 8'h3B, 16'hFE00, LOOPBACK ? 8'h00 : 8'h3B,
           0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
